// File: rtl/axicb_scfifo_lvl.sv
// ============================================================================
// Module   : axicb_scfifo_lvl
// Brief    : Single-clock FIFO with optional output register, fill level,
//            programmable almost-full/almost-empty and sticky error flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axicb_scfifo_lvl #(
   parameter int PASS_THRU     = 0,
   parameter int OUT_REG       = 0,
   parameter int ADDR_WIDTH    = 8,
   parameter int DATA_WIDTH    = 8,
   parameter int AFULL_THRESH  = 2**ADDR_WIDTH - 2,
   parameter int AEMPTY_THRESH = 1
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic                  srst,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  push,
   output logic                  full,
   output logic                  almost_full,
   output logic [DATA_WIDTH-1:0] data_out,
   input  logic                  pull,
   output logic                  empty,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH+1:0] level,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam int PTR_W = ADDR_WIDTH + 1;
   localparam int LVL_W = ADDR_WIDTH + 2;
   localparam bit PT_EN = (PASS_THRU != 0) && (OUT_REG == 0);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [PTR_W-1:0]      wrptr_q, wrptr_d;
   logic [PTR_W-1:0]      rdptr_q, rdptr_d;
   logic                  ovf_q, ovf_d;
   logic                  unf_q, unf_d;

   logic                  clr;
   logic [PTR_W-1:0]      ram_cnt;
   logic                  ram_full;
   logic                  ram_empty;
   logic                  push_ok;
   logic                  pass;
   logic                  bypass;
   logic                  rd_req;
   logic                  wr_en;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] ram_rdata;

   assign clr       = srst | flush;
   assign ram_cnt   = wrptr_q - rdptr_q;
   assign ram_full  = (ram_cnt == PTR_W'(DEPTH));
   assign ram_empty = (ram_cnt == '0);
   assign push_ok   = push & ~ram_full;
   assign ram_rdata = mem_q[rdptr_q[ADDR_WIDTH-1:0]];

   // Forwarded or bypassed words never touch the RAM.
   assign pass  = PT_EN & pull & ram_empty;
   assign wr_en = push_ok & ~clr & ~pass & ~bypass;
   assign rd_en = rd_req & ~clr;

   assign full         = ram_full;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;
   assign almost_full  = (level >= LVL_W'(AFULL_THRESH));
   assign almost_empty = (level <= LVL_W'(AEMPTY_THRESH));

   always_comb begin
      wrptr_d = wrptr_q;
      rdptr_d = rdptr_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      if (clr) begin
         wrptr_d = '0;
         rdptr_d = '0;
         ovf_d   = 1'b0;
         unf_d   = 1'b0;
      end else begin
         if (wr_en)
            wrptr_d = wrptr_q + PTR_W'(1);
         if (rd_en)
            rdptr_d = rdptr_q + PTR_W'(1);
         if (push && ram_full)
            ovf_d = 1'b1;
         if (pull && empty)
            unf_d = 1'b1;
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         wrptr_q <= '0;
         rdptr_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         wrptr_q <= wrptr_d;
         rdptr_q <= rdptr_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   always_ff @(posedge aclk) begin
      if (wr_en)
         mem_q[wrptr_q[ADDR_WIDTH-1:0]] <= data_in;
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic                  out_vld_q, out_vld_d;
         logic [DATA_WIDTH-1:0] out_q, out_d;
         logic                  pull_ok;
         logic                  take;
         logic                  refill;

         assign pull_ok = pull & out_vld_q;
         assign take    = ~out_vld_q | pull_ok;
         assign bypass  = take & ram_empty & push_ok;
         assign refill  = take & ~ram_empty;
         assign rd_req  = refill;

         always_comb begin
            out_vld_d = out_vld_q;
            out_d     = out_q;
            if (clr) begin
               out_vld_d = 1'b0;
            end else if (bypass) begin
               out_d     = data_in;
               out_vld_d = 1'b1;
            end else if (refill) begin
               out_d     = ram_rdata;
               out_vld_d = 1'b1;
            end else if (pull_ok) begin
               out_vld_d = 1'b0;
            end
         end

         always_ff @(posedge aclk or posedge areset) begin
            if (areset) begin
               out_vld_q <= 1'b0;
               out_q     <= '0;
            end else begin
               out_vld_q <= out_vld_d;
               out_q     <= out_d;
            end
         end

         assign empty    = ~out_vld_q;
         assign data_out = out_q;
         assign level    = LVL_W'(ram_cnt) + LVL_W'(out_vld_q);
      end else begin : g_no_out_reg
         assign bypass   = 1'b0;
         assign rd_req   = pull & ~ram_empty;
         // Forwarding makes empty follow push, which also suppresses underflow.
         assign empty    = pass ? ~push : ram_empty;
         assign data_out = pass ? data_in : ram_rdata;
         assign level    = LVL_W'(ram_cnt);
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_axicb_scfifo_lvl.sv
// ============================================================================
// Module   : tb_axicb_scfifo_lvl
// Brief    : Directed vector table plus corner sequences and a queue-model
//            random run for axicb_scfifo_lvl in three configurations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axicb_scfifo_lvl;

   typedef struct {
      int         sel;
      logic       clr;
      logic       fl;
      logic       ps;
      logic       pl;
      logic [7:0] din;
      logic [3:0] lvl;
      logic       emp, ful, af, ae, ov, un;
      logic       dchk;
      logic [7:0] dout;
   } vec_t;

   logic       aclk;
   logic       areset;
   logic       srst;
   logic       flush;
   logic [7:0] data_in;
   logic       push;
   logic       pull;

   logic [2:0] full_s, af_s, empty_s, ae_s, ov_s, un_s;
   logic [7:0] dout_s [3];
   logic [3:0] lvl_s  [3];

   int n_chk  = 0;
   int n_fail = 0;

   vec_t vecs[$];
   logic [7:0] q0[$];
   logic [7:0] q1[$];

   // dut0: plain, dut1: registered output, dut2: pass-thru
   axicb_scfifo_lvl #(.PASS_THRU(0), .OUT_REG(0), .ADDR_WIDTH(2), .DATA_WIDTH(8),
                      .AFULL_THRESH(3), .AEMPTY_THRESH(1)) u_dut0 (
      .aclk(aclk), .areset(areset), .srst(srst), .flush(flush),
      .data_in(data_in), .push(push), .full(full_s[0]), .almost_full(af_s[0]),
      .data_out(dout_s[0]), .pull(pull), .empty(empty_s[0]),
      .almost_empty(ae_s[0]), .level(lvl_s[0]), .overflow(ov_s[0]),
      .underflow(un_s[0]));

   axicb_scfifo_lvl #(.PASS_THRU(0), .OUT_REG(1), .ADDR_WIDTH(2), .DATA_WIDTH(8)) u_dut1 (
      .aclk(aclk), .areset(areset), .srst(srst), .flush(flush),
      .data_in(data_in), .push(push), .full(full_s[1]), .almost_full(af_s[1]),
      .data_out(dout_s[1]), .pull(pull), .empty(empty_s[1]),
      .almost_empty(ae_s[1]), .level(lvl_s[1]), .overflow(ov_s[1]),
      .underflow(un_s[1]));

   axicb_scfifo_lvl #(.PASS_THRU(1), .OUT_REG(0), .ADDR_WIDTH(2), .DATA_WIDTH(8)) u_dut2 (
      .aclk(aclk), .areset(areset), .srst(srst), .flush(flush),
      .data_in(data_in), .push(push), .full(full_s[2]), .almost_full(af_s[2]),
      .data_out(dout_s[2]), .pull(pull), .empty(empty_s[2]),
      .almost_empty(ae_s[2]), .level(lvl_s[2]), .overflow(ov_s[2]),
      .underflow(un_s[2]));

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t v(input int sel, input logic clr, input logic fl,
                              input logic ps, input logic pl, input logic [7:0] din,
                              input logic [3:0] lvl, input logic emp, input logic ful,
                              input logic af, input logic ae, input logic ov,
                              input logic un, input logic dchk, input logic [7:0] dout);
      vec_t r;
      r.sel = sel; r.clr = clr; r.fl = fl; r.ps = ps; r.pl = pl; r.din = din;
      r.lvl = lvl; r.emp = emp; r.ful = ful; r.af = af; r.ae = ae; r.ov = ov;
      r.un = un; r.dchk = dchk; r.dout = dout;
      return r;
   endfunction

   task automatic sync_clear();
      srst = 1'b1; push = 1'b0; pull = 1'b0;
      @(posedge aclk); #1;
      srst = 1'b0;
   endtask

   task automatic push_one(input logic [7:0] d);
      push = 1'b1; pull = 1'b0; data_in = d;
      @(posedge aclk); #1;
      push = 1'b0;
   endtask

   initial begin
      // Plain FIFO: fill, overflow, drain, underflow, simultaneous ops, flush
      //      sel clr fl ps pl din    lvl emp ful af ae ov un dchk dout
      vecs.push_back(v(0,1,0,1,0,8'hFF, 0, 1,0,0,1,0,0, 0,8'h00));
      vecs.push_back(v(0,0,0,1,0,8'h11, 1, 0,0,0,1,0,0, 1,8'h11));
      vecs.push_back(v(0,0,0,1,0,8'h22, 2, 0,0,0,0,0,0, 1,8'h11));
      vecs.push_back(v(0,0,0,1,0,8'h33, 3, 0,0,1,0,0,0, 1,8'h11));
      vecs.push_back(v(0,0,0,1,0,8'h44, 4, 0,1,1,0,0,0, 1,8'h11));
      vecs.push_back(v(0,0,0,1,0,8'h55, 4, 0,1,1,0,1,0, 1,8'h11));
      vecs.push_back(v(0,0,0,0,1,8'h00, 3, 0,0,1,0,1,0, 1,8'h22));
      vecs.push_back(v(0,0,0,0,1,8'h00, 2, 0,0,0,0,1,0, 1,8'h33));
      vecs.push_back(v(0,0,0,0,1,8'h00, 1, 0,0,0,1,1,0, 1,8'h44));
      vecs.push_back(v(0,0,0,0,1,8'h00, 0, 1,0,0,1,1,0, 0,8'h00));
      vecs.push_back(v(0,0,0,0,1,8'h00, 0, 1,0,0,1,1,1, 0,8'h00));
      vecs.push_back(v(0,0,0,1,1,8'h66, 1, 0,0,0,1,1,1, 1,8'h66));
      vecs.push_back(v(0,0,0,1,1,8'h77, 1, 0,0,0,1,1,1, 1,8'h77));
      vecs.push_back(v(0,0,0,1,0,8'h88, 2, 0,0,0,0,1,1, 1,8'h77));
      vecs.push_back(v(0,0,0,1,0,8'h99, 3, 0,0,1,0,1,1, 1,8'h77));
      vecs.push_back(v(0,0,0,1,0,8'hAA, 4, 0,1,1,0,1,1, 1,8'h77));
      vecs.push_back(v(0,0,0,1,1,8'hBB, 3, 0,0,1,0,1,1, 1,8'h88));
      vecs.push_back(v(0,0,1,1,0,8'hCC, 0, 1,0,0,1,0,0, 0,8'h00));
      vecs.push_back(v(0,0,0,1,0,8'h77, 1, 0,0,0,1,0,0, 1,8'h77));
      // Registered output: capacity 5, bypass, refill, drain
      vecs.push_back(v(1,1,0,0,0,8'h00, 0, 1,0,0,1,0,0, 0,8'h00));
      vecs.push_back(v(1,0,0,1,0,8'hA1, 1, 0,0,0,1,0,0, 1,8'hA1));
      vecs.push_back(v(1,0,0,1,0,8'hA2, 2, 0,0,1,0,0,0, 1,8'hA1));
      vecs.push_back(v(1,0,0,1,0,8'hA3, 3, 0,0,1,0,0,0, 1,8'hA1));
      vecs.push_back(v(1,0,0,1,0,8'hA4, 4, 0,0,1,0,0,0, 1,8'hA1));
      vecs.push_back(v(1,0,0,1,0,8'hA5, 5, 0,1,1,0,0,0, 1,8'hA1));
      vecs.push_back(v(1,0,0,1,0,8'hA6, 5, 0,1,1,0,1,0, 1,8'hA1));
      vecs.push_back(v(1,0,0,0,1,8'h00, 4, 0,0,1,0,1,0, 1,8'hA2));
      vecs.push_back(v(1,0,0,0,1,8'h00, 3, 0,0,1,0,1,0, 1,8'hA3));
      vecs.push_back(v(1,0,0,0,1,8'h00, 2, 0,0,1,0,1,0, 1,8'hA4));
      vecs.push_back(v(1,0,0,0,1,8'h00, 1, 0,0,0,1,1,0, 1,8'hA5));
      vecs.push_back(v(1,0,0,0,1,8'h00, 0, 1,0,0,1,1,0, 0,8'h00));
      vecs.push_back(v(1,0,0,0,1,8'h00, 0, 1,0,0,1,1,1, 0,8'h00));
      vecs.push_back(v(1,0,0,1,1,8'hB1, 1, 0,0,0,1,1,1, 1,8'hB1));
      vecs.push_back(v(1,0,0,1,1,8'hB2, 1, 0,0,0,1,1,1, 1,8'hB2));
      vecs.push_back(v(1,0,0,1,0,8'hB3, 2, 0,0,1,0,1,1, 1,8'hB2));
      vecs.push_back(v(1,0,0,1,1,8'hB4, 2, 0,0,1,0,1,1, 1,8'hB3));
      vecs.push_back(v(1,0,0,0,1,8'h00, 1, 0,0,0,1,1,1, 1,8'hB4));
      vecs.push_back(v(1,0,1,0,0,8'h00, 0, 1,0,0,1,0,0, 0,8'h00));

      areset = 1'b1; srst = 1'b0; flush = 1'b0;
      push = 1'b0; pull = 1'b0; data_in = 8'h00;
      #12;
      chk("areset level0", lvl_s[0], 0);
      chk("areset empty0", empty_s[0], 1);
      chk("areset empty1", empty_s[1], 1);
      areset = 1'b0;
      @(posedge aclk); #1;

      for (int i = 0; i < vecs.size(); i++) begin
         int s;
         s = vecs[i].sel;
         srst = vecs[i].clr; flush = vecs[i].fl;
         push = vecs[i].ps;  pull  = vecs[i].pl; data_in = vecs[i].din;
         @(posedge aclk); #1;
         n_chk++;
         if ({empty_s[s], full_s[s], af_s[s], ae_s[s], ov_s[s], un_s[s], lvl_s[s]} !==
             {vecs[i].emp, vecs[i].ful, vecs[i].af, vecs[i].ae, vecs[i].ov, vecs[i].un, vecs[i].lvl}) begin
            n_fail++;
            $display("FAIL row%0d flags emp/ful/af/ae/ov/un lvl: got %b%b%b%b%b%b %0d, expected %b%b%b%b%b%b %0d",
                     i, empty_s[s], full_s[s], af_s[s], ae_s[s], ov_s[s], un_s[s], lvl_s[s],
                     vecs[i].emp, vecs[i].ful, vecs[i].af, vecs[i].ae, vecs[i].ov, vecs[i].un, vecs[i].lvl);
         end
         if (vecs[i].dchk)
            chk($sformatf("row%0d data_out", i), dout_s[s], vecs[i].dout);
      end
      srst = 1'b0; flush = 1'b0; push = 1'b0; pull = 1'b0;

      // Pass-thru: same-cycle forward, no state change
      sync_clear();
      push = 1'b1; pull = 1'b1; data_in = 8'hA5;
      #1;
      chk("pt comb data_out", dout_s[2], 8'hA5);
      chk("pt comb empty", empty_s[2], 0);
      @(posedge aclk); #1;
      chk("pt level", lvl_s[2], 0);
      chk("pt underflow", un_s[2], 0);
      chk("no-pt level", lvl_s[0], 1);
      chk("no-pt underflow", un_s[0], 1);
      push = 1'b0; pull = 1'b0;
      #1;
      chk("pt idle empty", empty_s[2], 1);
      push_one(8'h3C);
      chk("pt after level", lvl_s[2], 1);
      chk("pt after data", dout_s[2], 8'h3C);

      // Asynchronous reset between edges
      sync_clear();
      push_one(8'h5A);
      push_one(8'h5B);
      chk("pre-ar level0", lvl_s[0], 2);
      chk("pre-ar level1", lvl_s[1], 2);
      @(negedge aclk); #1;
      areset = 1'b1;
      #1;
      chk("ar level0", lvl_s[0], 0);
      chk("ar empty0", empty_s[0], 1);
      chk("ar level1", lvl_s[1], 0);
      chk("ar empty1", empty_s[1], 1);
      chk("ar aempty1", ae_s[1], 1);
      #1;
      areset = 1'b0;
      push_one(8'h6C);
      chk("post-ar level0", lvl_s[0], 1);
      chk("post-ar data0", dout_s[0], 8'h6C);
      chk("post-ar level1", lvl_s[1], 1);
      chk("post-ar data1", dout_s[1], 8'h6C);

      // Random traffic against reference queues
      sync_clear();
      for (int c = 0; c < 2000; c++) begin
         int sz0, sz1;
         push    = 1'($urandom_range(0, 1));
         pull    = 1'($urandom_range(0, 1));
         data_in = 8'($urandom);
         #1;
         sz0 = q0.size();
         sz1 = q1.size();
         chk("rnd level0", lvl_s[0], sz0);
         chk("rnd full0", full_s[0], (sz0 == 4));
         chk("rnd empty0", empty_s[0], (sz0 == 0));
         if (sz0 > 0) chk("rnd data0", dout_s[0], q0[0]);
         chk("rnd level1", lvl_s[1], sz1);
         chk("rnd full1", full_s[1], (sz1 == 5));
         chk("rnd empty1", empty_s[1], (sz1 == 0));
         if (sz1 > 0) chk("rnd data1", dout_s[1], q1[0]);
         if (pull && sz0 > 0) void'(q0.pop_front());
         if (push && sz0 < 4) q0.push_back(data_in);
         if (pull && sz1 > 0) void'(q1.pop_front());
         if (push && sz1 < 5) q1.push_back(data_in);
         @(posedge aclk); #1;
      end
      push = 1'b0; pull = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
